// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Decode-stage register scoreboard and stall control for loads,
//            multiplies and the single iterative multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_ADDR = 5,
  parameter int LD_LAT   = 2,
  parameter int MUL_LAT  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [REG_ADDR-1:0] src1,
  input  logic [REG_ADDR-1:0] src2,
  input  logic                use_src1,
  input  logic                use_src2,
  input  logic [REG_ADDR-1:0] dest_reg,
  input  logic                regwrite,
  input  logic                is_load,
  input  logic                is_mult,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic                mul_busy,
  output logic [15:0]         stall_cycles
);

  localparam int         c_NREG    = 1 << REG_ADDR;
  localparam logic [2:0] c_LD_LAT  = 3'(LD_LAT);
  localparam logic [2:0] c_MUL_LAT = 3'(MUL_LAT);

  logic [2:0]  w_cnt [c_NREG];
  logic [2:0]  r_mul_cnt;
  logic [15:0] r_stall_cycles;
  logic        w_active;
  logic [2:0]  w_lat_new;
  logic [2:0]  w_cnt_load;
  logic        w_raw;
  logic        w_waw;
  logic        w_struct;
  logic        w_stall;
  logic        w_issue;
  logic        w_track;

  assign w_active  = valid_in & ~flush;
  assign w_lat_new = is_load ? c_LD_LAT : (is_mult ? c_MUL_LAT : 3'd0);
  // Counts are kept as cycles still to wait as seen from the cycle after issue.
  assign w_cnt_load = w_lat_new - 3'd1;

  assign w_raw = w_active &
                 ((use_src1 & (src1 != '0) & (w_cnt[src1] != 3'd0)) |
                  (use_src2 & (src2 != '0) & (w_cnt[src2] != 3'd0)));
  assign w_waw = w_active & regwrite & (dest_reg != '0) &
                 (w_cnt[dest_reg] > w_lat_new);
  // The multiplier frees at the end of its last busy cycle, so a new one may start then.
  assign w_struct = w_active & is_mult & (r_mul_cnt > 3'd1);

  assign w_stall = w_raw | w_waw | w_struct;
  assign w_issue = w_active & ~w_stall;
  assign w_track = w_issue & regwrite & (dest_reg != '0) & (w_lat_new != 3'd0);

  assign stall        = w_stall;
  assign issue        = w_issue;
  assign mul_busy     = (r_mul_cnt != 3'd0);
  assign stall_cycles = r_stall_cycles;

  assign w_cnt[0] = 3'd0;

  genvar r;
  generate
    for (r = 1; r < c_NREG; r++) begin : g_reg
      logic [2:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= 3'd0;
        end else if (w_track && (dest_reg == REG_ADDR'(r))) begin
          r_cnt <= w_cnt_load;
        end else if (r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
        end
      end

      assign w_cnt[r] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mul_cnt <= 3'd0;
    end else if (w_issue && is_mult) begin
      r_mul_cnt <= c_MUL_LAT;
    end else if (r_mul_cnt != 3'd0) begin
      r_mul_cnt <= r_mul_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 16'd0;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        use_src1;
  logic        use_src2;
  logic [4:0]  dest_reg;
  logic        regwrite;
  logic        is_load;
  logic        is_mult;
  logic        flush;
  logic        stall;
  logic        issue;
  logic        mul_busy;
  logic [15:0] stall_cycles;

  int n_compared   = 0;
  int n_mismatched = 0;

  hazard_scoreboard #(
    .REG_ADDR (5),
    .LD_LAT   (2),
    .MUL_LAT  (5)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .src1         (src1),
    .src2         (src2),
    .use_src1     (use_src1),
    .use_src2     (use_src2),
    .dest_reg     (dest_reg),
    .regwrite     (regwrite),
    .is_load      (is_load),
    .is_mult      (is_mult),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .mul_busy     (mul_busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] d,
                       input logic rw, input logic ld, input logic ml, input logic fl);
    valid_in = v;  src1 = s1; use_src1 = u1; src2 = s2; use_src2 = u2;
    dest_reg = d;  regwrite = rw; is_load = ld; is_mult = ml; flush = fl;
    #1;
  endtask

  task automatic idle();             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ldw(input logic [4:0] d, input logic [4:0] a);
    drive(1, a, 1, 0, 0, d, 1, 1, 0, 0);
  endtask
  task automatic mul(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    drive(1, a, 1, b, 1, d, 1, 0, 1, 0);
  endtask
  task automatic add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    drive(1, a, 1, b, 1, d, 1, 0, 0, 0);
  endtask
  task automatic addi(input logic [4:0] d, input logic [4:0] a);
    drive(1, a, 1, 0, 0, d, 1, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_mul_busy", 16'(mul_busy), 16'd0);
    check("rst_stall_cycles", stall_cycles, 16'd0);
    reset = 1'b1;

    // Load-use: exactly one bubble
    ldw(3, 1);
    check("lu_ld_issue", 16'(issue), 16'd1);
    tick();
    add(4, 3, 5);
    check("lu_stall", 16'(stall), 16'd1);
    check("lu_no_issue", 16'(issue), 16'd0);
    tick();
    #1;
    check("lu_stall_gone", 16'(stall), 16'd0);
    check("lu_issue", 16'(issue), 16'd1);
    check("lu_stall_cycles", stall_cycles, 16'd1);
    tick();

    // Multiply chain
    mul(6, 1, 2);
    check("mc_mul1_issue", 16'(issue), 16'd1);
    tick();
    mul(7, 1, 2);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("mc_mul2_stall_%0d", k), 16'(stall), 16'd1);
      check($sformatf("mc_busy_%0d", k), 16'(mul_busy), 16'd1);
      tick();
    end
    #1;
    check("mc_mul2_issue", 16'(issue), 16'd1);
    check("mc_busy_5", 16'(mul_busy), 16'd1);
    tick();
    add(9, 6, 0);
    check("mc_add_r6_issue", 16'(issue), 16'd1);
    check("mc_busy_again", 16'(mul_busy), 16'd1);
    tick();
    add(10, 7, 0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("mc_add_r7_stall_%0d", k), 16'(stall), 16'd1);
      tick();
    end
    #1;
    check("mc_add_r7_issue", 16'(issue), 16'd1);
    check("mc_stall_cycles", stall_cycles, 16'd8);
    tick();
    idle();
    check("mc_busy_clear", 16'(mul_busy), 16'd0);

    // WAW behind a pending multiply
    mul(8, 1, 2);
    check("waw_mul_issue", 16'(issue), 16'd1);
    tick();
    addi(8, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("waw_addi_stall_%0d", k), 16'(stall), 16'd1);
      tick();
    end
    #1;
    check("waw_addi_issue", 16'(issue), 16'd1);
    check("waw_stall_cycles", stall_cycles, 16'd12);
    tick();
    mul(8, 1, 2);
    check("waw_mul2_issue", 16'(issue), 16'd1);
    tick();
    ldw(8, 1);
    for (int k = 1; k <= 2; k++) begin
      check($sformatf("waw_ldw_stall_%0d", k), 16'(stall), 16'd1);
      tick();
    end
    #1;
    check("waw_ldw_issue", 16'(issue), 16'd1);
    check("waw_ldw_stall_cycles", stall_cycles, 16'd14);
    tick();

    // Register zero is never tracked
    ldw(0, 1);
    check("r0_ldw_issue", 16'(issue), 16'd1);
    tick();
    add(1, 0, 0);
    check("r0_add_stall", 16'(stall), 16'd0);
    check("r0_add_issue", 16'(issue), 16'd1);
    tick();

    // Flush during a load-use stall
    ldw(3, 1);
    check("fl_ld_issue", 16'(issue), 16'd1);
    tick();
    drive(1, 3, 1, 5, 1, 4, 1, 0, 0, 1);
    check("fl_stall", 16'(stall), 16'd0);
    check("fl_issue", 16'(issue), 16'd0);
    tick();
    add(4, 3, 5);
    check("fl_after_stall", 16'(stall), 16'd0);
    check("fl_after_issue", 16'(issue), 16'd1);
    check("fl_stall_cycles", stall_cycles, 16'd14);
    tick();

    // Asynchronous reset in the middle of a structural stall
    mul(10, 1, 2);
    check("rs_mul_issue", 16'(issue), 16'd1);
    tick();
    idle();
    tick();
    mul(11, 1, 2);
    check("rs_pre_stall", 16'(stall), 16'd1);
    check("rs_pre_busy", 16'(mul_busy), 16'd1);
    reset = 1'b0;
    #1;
    check("rs_stall", 16'(stall), 16'd0);
    check("rs_busy", 16'(mul_busy), 16'd0);
    check("rs_stall_cycles", stall_cycles, 16'd0);
    check("rs_issue", 16'(issue), 16'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rs_post_issue", 16'(issue), 16'd1);
    check("rs_post_stall", 16'(stall), 16'd0);
    tick();
    idle();
    check("rs_post_busy", 16'(mul_busy), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
